// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU datapath blocks. The serial adder
// uses them today. Future serial subtractor and multiplier blocks are meant to
// reuse the same definitions.
//   ALU_WIDTH       default operand width of the serial ALU blocks
//   serial_state_e  common IDLE / RUN / DONE sequencing state
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_e;

endpackage : alu_pkg

// File: rtl/serial_adder_8bit_adder_1bit.sv
// ----------------------------------------------------------------------------
// Adder_1bit
// Purely combinational one-bit full adder. The serial adder instantiates it
// once and reuses it on every bit position, one bit per clock.
// Ports:
//   a, b       operand bits
//   carry_in   incoming carry
//   sum        a ^ b ^ carry_in
//   carry_out  majority(a, b, carry_in)
// ----------------------------------------------------------------------------
module Adder_1bit (
    output logic sum,
    output logic carry_out,
    input  logic a,
    input  logic b,
    input  logic carry_in
);

    logic half_sum;

    assign half_sum  = a ^ b;
    assign sum       = half_sum ^ carry_in;
    assign carry_out = (a & b) | (carry_in & half_sum);

endmodule : Adder_1bit

// File: rtl/serial_adder_8bit.sv
// ----------------------------------------------------------------------------
// serial_adder_8bit
// Bit-serial adder: {carry_out, sum} = A + B + carry_in, computed LSB first
// through a single full-adder cell, one bit per clock.
// Optional feature macro: OVERFLOW_FLAG_EN adds the two's-complement overflow
// output and the operand-MSB capture logic that feeds it.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (A, B, carry_in sampled in IDLE)
//   A, B, carry_in       operands
//   out_valid/out_ready  result handshake (result held while in DONE)
//   sum, carry_out       registered result; keeps its last value afterwards
//   overflow             two's-complement overflow (OVERFLOW_FLAG_EN only)
// Latency is WIDTH cycles from accept to out_valid. With out_ready held high,
// throughput is one operation per WIDTH+2 cycles.
// ----------------------------------------------------------------------------
module serial_adder_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH  // must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    serial_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic             fa_sum, fa_carry;

`ifdef OVERFLOW_FLAG_EN
    // The operands are shifted away while the sum is built. Their sign bits
    // are therefore kept separately for the overflow decision.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic overflow_q, overflow_d;
`endif

    Adder_1bit u_adder (
        .sum       (fa_sum),
        .carry_out (fa_carry),
        .a         (a_sr_q[0]),
        .b         (b_sr_q[0]),
        .carry_in  (carry_q)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
`ifdef OVERFLOW_FLAG_EN
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        overflow_d = overflow_q;
`endif

        unique case (state_q)
            IDLE: begin
                // in_ready is exactly (state_q == IDLE), so in_valid alone
                // qualifies the accept here.
                if (in_valid) begin
                    a_sr_d  = A;
                    b_sr_d  = B;
                    carry_d = carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef OVERFLOW_FLAG_EN
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
`endif
                end
            end

            RUN: begin
                // Right shift: each new sum bit enters at the MSB. After WIDTH
                // steps, bit 0 of the result has reached position 0.
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
`ifdef OVERFLOW_FLAG_EN
                    // fa_sum is the result MSB on this last step.
                    overflow_d = (a_msb_q == b_msb_q) && (fa_sum != a_msb_q);
`endif
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only. Every flop then
    // samples its pre-edge value, regardless of the order the blocks execute in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

    // All outputs come straight from flops or from a decode of the state flop.
    // No input reaches an output combinationally.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_sr_q;
    assign carry_out = carry_q;

endmodule : serial_adder_8bit
